wallace_tree_multiplier_8x8: RTL and testbench



---
 rtl/wallace_tree_multiplier_8x8.sv | 113 +++++++++++
 tb/tb_wallace_tree_multiplier_8x8.sv | 119 +++++++++++
 2 files changed

// File: rtl/wallace_tree_multiplier_8x8.sv
// rtl/wallace_tree_multiplier_8x8.sv - unsigned 8x8 Wallace-tree multiplier with registered 16-bit product
// Tree stages 8 -> 6 -> 4 -> 3 -> 2 rows of carry-save adders, then a ripple CPA into the output register.

module wallace_fa (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ c;
   assign co = (a & b) | (a & c) | (b & c);
endmodule

module wallace_ha (
   input  logic a,
   input  logic b,
   output logic s,
   output logic co
);
   assign s  = a ^ b;
   assign co = a & b;
endmodule

// 3:2 row compressor: sums stay in their column, carries move one column left.
// The column-15 carry would weigh 2^16; every row sum here is below 2^16, so it is provably zero.
module wallace_csa (
   input  logic [15:0] x,
   input  logic [15:0] y,
   input  logic [15:0] z,
   output logic [15:0] sum,
   output logic [15:0] carry
);
   assign carry[0] = 1'b0;
   for (genvar i = 0; i < 15; i++) begin : g_col
      wallace_fa u_fa (
         .a (x[i]),
         .b (y[i]),
         .c (z[i]),
         .s (sum[i]),
         .co(carry[i+1])
      );
   end
   assign sum[15] = x[15] ^ y[15] ^ z[15];
endmodule

module wallace_cpa (
   input  logic [15:0] x,
   input  logic [15:0] y,
   output logic [15:0] sum
);
   logic [15:0] c;

   wallace_ha u_ha0 (
      .a (x[0]),
      .b (y[0]),
      .s (sum[0]),
      .co(c[1])
   );
   assign c[0] = 1'b0;
   for (genvar i = 1; i < 15; i++) begin : g_bit
      wallace_fa u_fa (
         .a (x[i]),
         .b (y[i]),
         .c (c[i]),
         .s (sum[i]),
         .co(c[i+1])
      );
   end
   assign sum[15] = x[15] ^ y[15] ^ c[15];
endmodule

module wallace_tree_multiplier_8x8 (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  A,
   input  logic [7:0]  B,
   output logic [15:0] Product
);
   logic [15:0] pp [8];
   logic [15:0] s1 [6];
   logic [15:0] s2 [4];
   logic [15:0] s3 [3];
   logic [15:0] s4 [2];
   logic [15:0] result;

   for (genvar i = 0; i < 8; i++) begin : g_pp
      assign pp[i] = {8'b0, A & {8{B[i]}}} << i;
   end

   wallace_csa u_s1a (.x(pp[0]), .y(pp[1]), .z(pp[2]), .sum(s1[0]), .carry(s1[1]));
   wallace_csa u_s1b (.x(pp[3]), .y(pp[4]), .z(pp[5]), .sum(s1[2]), .carry(s1[3]));
   assign s1[4] = pp[6];
   assign s1[5] = pp[7];

   wallace_csa u_s2a (.x(s1[0]), .y(s1[1]), .z(s1[2]), .sum(s2[0]), .carry(s2[1]));
   wallace_csa u_s2b (.x(s1[3]), .y(s1[4]), .z(s1[5]), .sum(s2[2]), .carry(s2[3]));

   wallace_csa u_s3a (.x(s2[0]), .y(s2[1]), .z(s2[2]), .sum(s3[0]), .carry(s3[1]));
   assign s3[2] = s2[3];

   wallace_csa u_s4a (.x(s3[0]), .y(s3[1]), .z(s3[2]), .sum(s4[0]), .carry(s4[1]));

   wallace_cpa u_cpa (.x(s4[0]), .y(s4[1]), .sum(result));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         Product <= 16'h0000;
      end else begin
         Product <= result;
      end
   end
endmodule

// File: tb/tb_wallace_tree_multiplier_8x8.sv
// tb/tb_wallace_tree_multiplier_8x8.sv - scoreboard bench for wallace_tree_multiplier_8x8
// Operands driven on the falling edge; the product of the previous pair is checked there too.

module tb_wallace_tree_multiplier_8x8;
   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  A;
   logic [7:0]  B;
   logic [15:0] Product;

   int n_vec = 0;
   int n_bad = 0;
   logic [15:0] exp_q [$];

   wallace_tree_multiplier_8x8 dut (
      .clk    (clk),
      .rst    (rst),
      .A      (A),
      .B      (B),
      .Product(Product)
   );

   always #5 clk = ~clk;

   task automatic expect_eq(input string tag, input logic [15:0] got, input logic [15:0] want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (A=%0d B=%0d)", tag, got, want, A, B);
      end
   endtask

   task automatic check_front(input string tag);
      logic [15:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         expect_eq(tag, Product, e);
      end
   endtask

   task automatic step(input string tag, input logic [7:0] a, input logic [7:0] b);
      logic [15:0] ref_p;
      @(negedge clk);
      check_front(tag);
      A = a;
      B = b;
      ref_p = 16'(a) * 16'(b);
      exp_q.push_back(ref_p);
   endtask

   task automatic drain(input string tag);
      @(negedge clk);
      check_front(tag);
   endtask

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
   } vec_t;

   vec_t dir_vecs [20] = '{
      '{8'd0,   8'd0},   '{8'd5,   8'd7},   '{8'd16,  8'd7},   '{8'd0,   8'd213},
      '{8'd16,  8'd213}, '{8'd115, 8'd213}, '{8'd115, 8'd12},  '{8'd210, 8'd12},
      '{8'd210, 8'd11},  '{8'd101, 8'd11},  '{8'd101, 8'd216}, '{8'd127, 8'd216},
      '{8'd127, 8'd223}, '{8'd29,  8'd223}, '{8'd29,  8'd255}, '{8'd255, 8'd255},
      '{8'd255, 8'd1},   '{8'd128, 8'd128}, '{8'd255, 8'd255}, '{8'd1,   8'd0}
   };

   initial begin
      rst = 1'b1;
      A   = 8'd255;
      B   = 8'd255;
      #1;
      expect_eq("rst_async_init", Product, 16'h0000);
      repeat (3) begin
         @(negedge clk);
         expect_eq("rst_hold", Product, 16'h0000);
      end
      @(negedge clk);
      rst = 1'b0;
      A = 8'd0;
      B = 8'd0;
      exp_q.push_back(16'd0);

      foreach (dir_vecs[i]) step("directed", dir_vecs[i].a, dir_vecs[i].b);

      for (int a = 0; a < 256; a++) begin
         for (int b = 0; b < 256; b++) begin
            step("exhaustive", 8'(a), 8'(b));
         end
      end

      step("pre_reset", 8'd255, 8'd255);
      drain("pre_reset");

      // Assert reset between edges; the register must clear without a clock edge.
      #2;
      rst = 1'b1;
      A = 8'd77;
      B = 8'd3;
      #1;
      expect_eq("rst_async_mid", Product, 16'h0000);
      exp_q.delete();
      @(posedge clk);
      #1;
      expect_eq("rst_edge_ignored", Product, 16'h0000);

      @(negedge clk);
      rst = 1'b0;
      A = 8'd200;
      B = 8'd100;
      exp_q.push_back(16'd20000);
      step("post_release", 8'd3, 8'd9);
      drain("post_release");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
